kb_player_queue: RTL and testbench

//  PS/2 scancode decoder for up to 4 Tron players with a per-player turn queue.

---
 rtl/kb_player_queue.sv | 234 +++++++++++++++++++++++
 tb/tb_kb_player_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_player_queue.sv
// PS/2 scancode decoder for up to four Tron players, each with a small turn FIFO.
// Direction encoding on dir_head (3 bits per player): NONE=0 UP=1 DOWN=2 LEFT=3 RIGHT=4.

module kb_player_lane #(
    parameter int QUEUE_DEPTH    = 2,
    parameter int REJECT_REVERSE = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic [2:0] push_dir,
    input  logic       pop,
    input  logic       flush,
    input  logic       boost_set,
    input  logic       boost_clr,
    output logic       valid,
    output logic [2:0] head,
    output logic       boost,
    output logic       overflow
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [2:0] D_NONE  = 3'd0;
    localparam logic [2:0] D_UP    = 3'd1;
    localparam logic [2:0] D_DOWN  = 3'd2;
    localparam logic [2:0] D_LEFT  = 3'd3;
    localparam logic [2:0] D_RIGHT = 3'd4;

    logic [QUEUE_DEPTH-1:0][2:0] q, q_nxt;
    logic [CW-1:0] cnt, cnt_nxt, wr_idx;
    logic [2:0]    heading, ref_dir;
    logic          do_pop, full, same, rev, take, accept, drop_full;

    function automatic logic is_opp(input logic [2:0] a, input logic [2:0] b);
        return (a == D_UP && b == D_DOWN) || (a == D_DOWN && b == D_UP) ||
               (a == D_LEFT && b == D_RIGHT) || (a == D_RIGHT && b == D_LEFT);
    endfunction

    // Reference heading is the newest queued turn, falling back to the committed heading.
    always_comb begin
        ref_dir = heading;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (cnt == CW'(i + 1)) ref_dir = q[i];
    end

    assign do_pop    = pop & (cnt != '0) & ~flush;
    assign full      = (cnt == CW'(QUEUE_DEPTH));
    assign same      = (push_dir == ref_dir);
    assign rev       = (REJECT_REVERSE != 0) && is_opp(push_dir, ref_dir);
    assign take      = push & ~same & ~rev;
    assign accept    = take & (~full | do_pop);
    assign drop_full = take & full & ~do_pop;
    assign wr_idx    = do_pop ? cnt - CW'(1) : cnt;
    assign cnt_nxt   = cnt + CW'(accept) - CW'(do_pop);

    always_comb begin
        q_nxt = q;
        if (do_pop)
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) q_nxt[i] = q[i+1];
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (accept && wr_idx == CW'(i)) q_nxt[i] = push_dir;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q        <= '0;
            cnt      <= '0;
            heading  <= D_NONE;
            boost    <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            cnt      <= '0;
            heading  <= D_NONE;
            boost    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            q        <= q_nxt;
            cnt      <= cnt_nxt;
            overflow <= drop_full;
            if (do_pop) heading <= q[0];
            if (boost_set)      boost <= 1'b1;
            else if (boost_clr) boost <= 1'b0;
        end
    end

    assign valid = (cnt != '0);
    assign head  = valid ? q[0] : D_NONE;
endmodule

module kb_player_queue #(
    parameter int NUM_PLAYERS    = 4,
    parameter int QUEUE_DEPTH    = 2,
    parameter int REJECT_REVERSE = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ps2_code_new,
    input  logic [7:0]               ps2_code,
    input  logic [NUM_PLAYERS-1:0]   dir_pop,
    output logic [NUM_PLAYERS-1:0]   dir_valid,
    output logic [NUM_PLAYERS*3-1:0] dir_head,
    output logic [NUM_PLAYERS-1:0]   boost,
    output logic [NUM_PLAYERS-1:0]   overflow,
    output logic                     reset_game,
    output logic [2:0]               reset_player_count,
    output logic                     toggle_border
);
    localparam logic [2:0] D_NONE  = 3'd0;
    localparam logic [2:0] D_UP    = 3'd1;
    localparam logic [2:0] D_DOWN  = 3'd2;
    localparam logic [2:0] D_LEFT  = 3'd3;
    localparam logic [2:0] D_RIGHT = 3'd4;

    typedef enum logic [1:0] {P_NONE, P_EXT, P_BRK, P_EXT_BRK} prefix_t;

    prefix_t    state;
    logic       s1, s2, s3, strobe;
    logic       ext, brk, is_prefix, key_strobe, plain_make;
    logic       turn_hit, boost_hit, rst_hit, cnt_load, border_hit, flush;
    logic [1:0] turn_pl, boost_pl;
    logic [2:0] turn_dir, cnt_val;

    function automatic logic [2:0] clamp_count(input int n);
        return (n > NUM_PLAYERS) ? 3'(NUM_PLAYERS) : 3'(n);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ps2_code_new;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign strobe = s2 & ~s3;
    assign ext    = (state == P_EXT) || (state == P_EXT_BRK);
    assign brk    = (state == P_BRK) || (state == P_EXT_BRK);
    // E0/F0 are only prefixes where a legal transition exists; elsewhere they decode as unmapped codes.
    assign is_prefix  = (ps2_code == 8'hE0 && (state == P_NONE || state == P_BRK)) ||
                        (ps2_code == 8'hF0 && (state == P_NONE || state == P_EXT));
    assign key_strobe = strobe & ~is_prefix;
    assign plain_make = key_strobe & ~ext & ~brk;

    always_comb begin
        turn_hit   = 1'b0;
        turn_pl    = 2'd0;
        turn_dir   = D_NONE;
        boost_hit  = 1'b0;
        boost_pl   = 2'd0;
        rst_hit    = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = 3'(NUM_PLAYERS);
        border_hit = 1'b0;
        if (ext) begin
            case (ps2_code)
                8'h75: begin turn_hit = 1'b1; turn_pl = 2'd1; turn_dir = D_UP;    end
                8'h72: begin turn_hit = 1'b1; turn_pl = 2'd1; turn_dir = D_DOWN;  end
                8'h6B: begin turn_hit = 1'b1; turn_pl = 2'd1; turn_dir = D_LEFT;  end
                8'h74: begin turn_hit = 1'b1; turn_pl = 2'd1; turn_dir = D_RIGHT; end
                default: ;
            endcase
        end else begin
            case (ps2_code)
                8'h1D: begin turn_hit = 1'b1; turn_pl = 2'd0; turn_dir = D_UP;    end
                8'h1B: begin turn_hit = 1'b1; turn_pl = 2'd0; turn_dir = D_DOWN;  end
                8'h1C: begin turn_hit = 1'b1; turn_pl = 2'd0; turn_dir = D_LEFT;  end
                8'h23: begin turn_hit = 1'b1; turn_pl = 2'd0; turn_dir = D_RIGHT; end
                8'h43: begin turn_hit = 1'b1; turn_pl = 2'd2; turn_dir = D_UP;    end
                8'h42: begin turn_hit = 1'b1; turn_pl = 2'd2; turn_dir = D_DOWN;  end
                8'h3B: begin turn_hit = 1'b1; turn_pl = 2'd2; turn_dir = D_LEFT;  end
                8'h4B: begin turn_hit = 1'b1; turn_pl = 2'd2; turn_dir = D_RIGHT; end
                8'h2C: begin turn_hit = 1'b1; turn_pl = 2'd3; turn_dir = D_UP;    end
                8'h34: begin turn_hit = 1'b1; turn_pl = 2'd3; turn_dir = D_DOWN;  end
                8'h2B: begin turn_hit = 1'b1; turn_pl = 2'd3; turn_dir = D_LEFT;  end
                8'h33: begin turn_hit = 1'b1; turn_pl = 2'd3; turn_dir = D_RIGHT; end
                8'h24: begin boost_hit = 1'b1; boost_pl = 2'd0; end
                8'h70: begin boost_hit = 1'b1; boost_pl = 2'd1; end
                8'h44: begin boost_hit = 1'b1; boost_pl = 2'd2; end
                8'h35: begin boost_hit = 1'b1; boost_pl = 2'd3; end
                8'h1E: begin rst_hit = 1'b1; cnt_load = 1'b1; cnt_val = clamp_count(2); end
                8'h26: begin rst_hit = 1'b1; cnt_load = 1'b1; cnt_val = clamp_count(3); end
                8'h25: begin rst_hit = 1'b1; cnt_load = 1'b1; cnt_val = clamp_count(4); end
                8'h29: rst_hit = 1'b1;
                8'h32: border_hit = 1'b1;
                default: ;
            endcase
        end
    end

    assign flush = plain_make & rst_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= P_NONE;
            reset_game         <= 1'b0;
            toggle_border      <= 1'b0;
            reset_player_count <= 3'(NUM_PLAYERS);
        end else begin
            reset_game    <= flush;
            toggle_border <= plain_make & border_hit;
            if (plain_make && cnt_load) reset_player_count <= cnt_val;
            if (strobe) begin
                if (ps2_code == 8'hE0 && state == P_NONE)      state <= P_EXT;
                else if (ps2_code == 8'hE0 && state == P_BRK)  state <= P_EXT_BRK;
                else if (ps2_code == 8'hF0 && state == P_NONE) state <= P_BRK;
                else if (ps2_code == 8'hF0 && state == P_EXT)  state <= P_EXT_BRK;
                else                                           state <= P_NONE;
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
        kb_player_lane #(
            .QUEUE_DEPTH   (QUEUE_DEPTH),
            .REJECT_REVERSE(REJECT_REVERSE)
        ) u_lane (
            .clock    (clock),
            .reset_n  (reset_n),
            .push     (key_strobe & ~brk & turn_hit & (turn_pl == 2'(p))),
            .push_dir (turn_dir),
            .pop      (dir_pop[p]),
            .flush    (flush),
            .boost_set(key_strobe & ~brk & boost_hit & (boost_pl == 2'(p))),
            .boost_clr(key_strobe & brk & boost_hit & (boost_pl == 2'(p))),
            .valid    (dir_valid[p]),
            .head     (dir_head[p*3 +: 3]),
            .boost    (boost[p]),
            .overflow (overflow[p])
        );
    end
endmodule

// File: tb/tb_kb_player_queue.sv
// Scenario bench for kb_player_queue: a 4-player instance plus 2- and 3-player instances on the same keyboard.

module tb_kb_player_queue;
    localparam logic [2:0] NONE = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_code_new = 1'b0;
    logic [7:0]  ps2_code = 8'h00;
    logic [3:0]  dir_pop = '0;
    logic [3:0]  dir_valid, boost, overflow;
    logic [11:0] dir_head;
    logic        reset_game, toggle_border;
    logic [2:0]  reset_player_count;

    logic [1:0]  pop2 = '0, valid2, boost2, ovf2;
    logic [5:0]  head2;
    logic        rg2, tb2;
    logic [2:0]  cnt2;

    logic [2:0]  pop3 = '0, valid3, boost3, ovf3;
    logic [8:0]  head3;
    logic        rg3, tb3;
    logic [2:0]  cnt3;

    int checks = 0;
    int errors = 0;
    int ovf_n, ovf_at, rg_n, rg_at, rg3_n, rg3_at, tg_n, tg_at;
    logic [2:0] exp_q [$];

    always #5 clock = ~clock;

    kb_player_queue dut (
        .clock(clock), .reset_n(reset_n), .ps2_code_new(ps2_code_new), .ps2_code(ps2_code),
        .dir_pop(dir_pop), .dir_valid(dir_valid), .dir_head(dir_head), .boost(boost),
        .overflow(overflow), .reset_game(reset_game), .reset_player_count(reset_player_count),
        .toggle_border(toggle_border));

    kb_player_queue #(.NUM_PLAYERS(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .ps2_code_new(ps2_code_new), .ps2_code(ps2_code),
        .dir_pop(pop2), .dir_valid(valid2), .dir_head(head2), .boost(boost2),
        .overflow(ovf2), .reset_game(rg2), .reset_player_count(cnt2), .toggle_border(tb2));

    kb_player_queue #(.NUM_PLAYERS(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .ps2_code_new(ps2_code_new), .ps2_code(ps2_code),
        .dir_pop(pop3), .dir_valid(valid3), .dir_head(head3), .boost(boost3),
        .overflow(ovf3), .reset_game(rg3), .reset_player_count(cnt3), .toggle_border(tb3));

    // One keyboard code; pulses are counted with the cycle (1..6 after the rise) they first appear.
    task automatic send(input logic [7:0] c, input logic [3:0] popm);
        @(negedge clock);
        ps2_code = c;
        ps2_code_new = 1'b1;
        ovf_n = 0; ovf_at = 0; rg_n = 0; rg_at = 0; rg3_n = 0; rg3_at = 0; tg_n = 0; tg_at = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) dir_pop = popm;
            @(posedge clock);
            #1;
            if (k == 3) dir_pop = '0;
            if (k == 4) ps2_code_new = 1'b0;
            if (overflow[0])  begin ovf_n++; if (ovf_n == 1) ovf_at = k; end
            if (reset_game)   begin rg_n++;  if (rg_n == 1)  rg_at = k;  end
            if (rg3)          begin rg3_n++; if (rg3_n == 1) rg3_at = k; end
            if (toggle_border) begin tg_n++; if (tg_n == 1)  tg_at = k;  end
        end
    endtask

    // Pops every scoreboard entry of player p, comparing the head, then expects an empty queue.
    task automatic drain_player(input int p);
        logic [2:0] exp;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (dir_valid[p] !== 1'b1 || dir_head[p*3 +: 3] !== exp) begin
                errors++;
                $display("FAIL drain_p%0d: valid=%b head=%0d, required valid=1 head=%0d",
                         p, dir_valid[p], dir_head[p*3 +: 3], exp);
            end
            dir_pop[p] = 1'b1;
            @(negedge clock);
            dir_pop = '0;
        end
        @(negedge clock);
        checks++;
        if (dir_valid[p] !== 1'b0 || dir_head[p*3 +: 3] !== NONE) begin
            errors++;
            $display("FAIL empty_p%0d: valid=%b head=%0d, required valid=0 head=0",
                     p, dir_valid[p], dir_head[p*3 +: 3]);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (dir_valid !== 4'h0 || dir_head !== 12'h000 || boost !== 4'h0 || overflow !== 4'h0 ||
            reset_game !== 1'b0 || toggle_border !== 1'b0 || reset_player_count !== 3'd4) begin
            errors++;
            $display("FAIL reset_state: valid=%h head=%h boost=%h ovf=%h rg=%b tg=%b cnt=%0d, required all 0, cnt=4",
                     dir_valid, dir_head, boost, overflow, reset_game, toggle_border, reset_player_count);
        end
        checks++;
        if (cnt2 !== 3'd2 || cnt3 !== 3'd3) begin
            errors++;
            $display("FAIL reset_count_small: cnt2=%0d cnt3=%0d, required 2 and 3", cnt2, cnt3);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_turns;
        send(8'h1D, 4'h0); exp_q.push_back(UP);
        send(8'h23, 4'h0); exp_q.push_back(RIGHT);
        checks++;
        if (dir_valid !== 4'b0001) begin
            errors++;
            $display("FAIL turns_valid: dir_valid=%b, required 0001", dir_valid);
        end
        drain_player(0);
    endtask

    task automatic test_extended;
        send(8'hE0, 4'h0); send(8'h75, 4'h0); exp_q.push_back(UP);
        checks++;
        if (dir_valid !== 4'b0010 || dir_head[5:3] !== UP) begin
            errors++;
            $display("FAIL arrow_up: valid=%b head1=%0d, required 0010 and 1", dir_valid, dir_head[5:3]);
        end
        send(8'hE0, 4'h0); send(8'hF0, 4'h0); send(8'h75, 4'h0);
        send(8'h75, 4'h0);
        drain_player(1);
    endtask

    task automatic test_typematic;
        for (int i = 0; i < 5; i++) send(8'h1D, 4'h0);
        exp_q.push_back(UP);
        send(8'h1B, 4'h0);
        drain_player(0);
    endtask

    task automatic test_overflow;
        send(8'h1C, 4'h0); exp_q.push_back(LEFT);
        checks++;
        if (ovf_n !== 0) begin
            errors++;
            $display("FAIL ovf_none_first: pulses=%0d, required 0", ovf_n);
        end
        send(8'h1D, 4'h0); exp_q.push_back(UP);
        send(8'h23, 4'h0);
        checks++;
        if (ovf_n !== 1 || ovf_at !== 3) begin
            errors++;
            $display("FAIL ovf_pulse: pulses=%0d at=%0d, required 1 at cycle 3", ovf_n, ovf_at);
        end
        checks++;
        if (dir_head[2:0] !== LEFT) begin
            errors++;
            $display("FAIL ovf_head: head0=%0d, required 3", dir_head[2:0]);
        end
        send(8'h23, 4'b0001);
        void'(exp_q.pop_front());
        exp_q.push_back(RIGHT);
        checks++;
        if (ovf_n !== 0 || overflow !== 4'h0) begin
            errors++;
            $display("FAIL ovf_with_pop: pulses=%0d, required 0", ovf_n);
        end
        drain_player(0);
    endtask

    task automatic test_back_to_back;
        send(8'h2C, 4'h0); exp_q.push_back(UP);
        send(8'h33, 4'h0); exp_q.push_back(RIGHT);
        drain_player(3);
        send(8'h32, 4'h0);
        checks++;
        if (tg_n !== 1 || tg_at !== 3 || rg_n !== 0) begin
            errors++;
            $display("FAIL border_pulse: tg=%0d at=%0d rg=%0d, required 1 at 3, rg 0", tg_n, tg_at, rg_n);
        end
    endtask

    task automatic test_boost;
        send(8'h29, 4'h0);
        checks++;
        if (rg_n !== 1 || rg_at !== 3 || reset_player_count !== 3'd4) begin
            errors++;
            $display("FAIL space_reset: rg=%0d at=%0d cnt=%0d, required 1 at 3, cnt 4", rg_n, rg_at, reset_player_count);
        end
        send(8'h24, 4'h0);
        checks++;
        if (boost !== 4'b0001) begin
            errors++;
            $display("FAIL boost_make: boost=%b, required 0001", boost);
        end
        send(8'hF0, 4'h0); send(8'h24, 4'h0);
        checks++;
        if (boost !== 4'b0000) begin
            errors++;
            $display("FAIL boost_break: boost=%b, required 0000", boost);
        end
        send(8'h43, 4'h0); send(8'h44, 4'h0);
        checks++;
        if (dir_valid !== 4'b0100 || dir_head[8:6] !== UP || boost !== 4'b0100) begin
            errors++;
            $display("FAIL p2_keys: valid=%b head2=%0d boost=%b, required 0100/1/0100", dir_valid, dir_head[8:6], boost);
        end
        checks++;
        if (valid2 !== 2'b00 || boost2 !== 2'b00 || head2 !== 6'h00) begin
            errors++;
            $display("FAIL p2_ignored_np2: valid=%b boost=%b head=%h, required 0", valid2, boost2, head2);
        end
    endtask

    task automatic test_control;
        send(8'h25, 4'h0);
        checks++;
        if (rg3_n !== 1 || rg3_at !== 3 || cnt3 !== 3'd3 || reset_player_count !== 3'd4) begin
            errors++;
            $display("FAIL count4_clamp: rg3=%0d at=%0d cnt3=%0d cnt=%0d, required 1 at 3, 3, 4",
                     rg3_n, rg3_at, cnt3, reset_player_count);
        end
        checks++;
        if (dir_valid !== 4'h0 || boost !== 4'h0 || valid3 !== 3'h0) begin
            errors++;
            $display("FAIL flush: valid=%b boost=%b valid3=%b, required 0", dir_valid, boost, valid3);
        end
        exp_q.delete();
        send(8'h1E, 4'h0);
        checks++;
        if (reset_player_count !== 3'd2 || cnt3 !== 3'd2 || rg_n !== 1) begin
            errors++;
            $display("FAIL count2: cnt=%0d cnt3=%0d rg=%0d, required 2 2 1", reset_player_count, cnt3, rg_n);
        end
        send(8'hF0, 4'h0);
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (reset_player_count !== 3'd4) begin
            errors++;
            $display("FAIL reset_count_restore: cnt=%0d, required 4", reset_player_count);
        end
        reset_n = 1'b1;
        send(8'h1D, 4'h0); exp_q.push_back(UP);
        drain_player(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_turns();
        test_extended();
        test_typematic();
        test_overflow();
        test_back_to_back();
        test_boost();
        test_control();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
